// File: rtl/scan_pkg.sv
// Shared defaults for the multiplexed seven-segment scanner: timing, widths and drive polarity.
package scan_pkg;

    localparam int DEF_NUM_DIGITS       = 4;
    localparam int DEF_SEG_WIDTH        = 8;
    localparam int DEF_DIGIT_CYCLES     = 200000;
    localparam int DEF_BLANK_CYCLES     = 500;
    localparam int DEF_BRIGHT_W         = 4;
    localparam int DEF_ANODE_ACTIVE_LOW = 1;
    localparam int DEF_SEG_ACTIVE_LOW   = 1;

    // Counter/index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer for the digit scanner: slot counter, digit index and the per-cycle
// slot/frame/window flags plus the PWM phase within the active window.
module scan_timer
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int BRIGHT_W     = DEF_BRIGHT_W,
    localparam int IW          = idx_width(NUM_DIGITS)
) (
    input  logic                clock,
    input  logic                reset,
    output logic [IW-1:0]       idx,
    output logic                slot_start,
    output logic                frame_end,
    output logic                in_active,
    output logic [BRIGHT_W-1:0] phase
);

    localparam int CW = idx_width(DIGIT_CYCLES);

    logic [CW-1:0] cnt;
    logic          slot_end;
    logic          last_digit;

    assign slot_end   = (cnt == CW'(DIGIT_CYCLES - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign slot_start = (cnt == '0);
    assign frame_end  = slot_end && last_digit;
    assign in_active  = (cnt >= CW'(BLANK_CYCLES));

    // Offset from the end of the blank window, reduced modulo 2^BRIGHT_W.
    assign phase = BRIGHT_W'({{BRIGHT_W{1'b0}}, cnt} - (CW + BRIGHT_W)'(BLANK_CYCLES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_digit ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: double-buffered patterns swapped at frame
// boundaries, per-slot brightness/enable sampling, PWM gating and registered outputs.
module seven_seg_scanner
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS       = DEF_NUM_DIGITS,
    parameter int SEG_WIDTH        = DEF_SEG_WIDTH,
    parameter int DIGIT_CYCLES     = DEF_DIGIT_CYCLES,
    parameter int BLANK_CYCLES     = DEF_BLANK_CYCLES,
    parameter int BRIGHT_W         = DEF_BRIGHT_W,
    parameter int ANODE_ACTIVE_LOW = DEF_ANODE_ACTIVE_LOW,
    parameter int SEG_ACTIVE_LOW   = DEF_SEG_ACTIVE_LOW
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_DIGITS*SEG_WIDTH-1:0] digits_in,
    input  logic                            load,
    input  logic [NUM_DIGITS-1:0]           digit_en,
    input  logic [BRIGHT_W-1:0]             brightness,
    output logic [NUM_DIGITS-1:0]           anode_out,
    output logic [SEG_WIDTH-1:0]            seg_out,
    output logic                            frame_start
);

    localparam int IW = idx_width(NUM_DIGITS);

    // Inactive drive levels; XOR with these converts internal active-high to pin polarity.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [SEG_WIDTH-1:0]  SEG_OFF   =
        (SEG_ACTIVE_LOW != 0) ? {SEG_WIDTH{1'b1}} : {SEG_WIDTH{1'b0}};

    logic [IW-1:0]         idx;
    logic                  slot_start;
    logic                  frame_end;
    logic                  in_active;
    logic [BRIGHT_W-1:0]   phase;

    logic [BRIGHT_W-1:0]   bright_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic [BRIGHT_W-1:0]   bright_eff;
    logic [NUM_DIGITS-1:0] en_eff;

    logic [SEG_WIDTH-1:0]  pend [NUM_DIGITS];
    logic [SEG_WIDTH-1:0]  disp [NUM_DIGITS];
    logic                  pend_valid;

    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_nxt;
    logic [SEG_WIDTH-1:0]  seg_nxt;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BRIGHT_W    (BRIGHT_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .idx       (idx),
        .slot_start(slot_start),
        .frame_end (frame_end),
        .in_active (in_active),
        .phase     (phase)
    );

    // Slot cycle 0 uses the live inputs so a zero-length blank window still sees them.
    assign bright_eff = slot_start ? brightness : bright_q;
    assign en_eff     = slot_start ? digit_en   : en_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bright_q <= '0;
            en_q     <= '0;
        end else if (slot_start) begin
            bright_q <= brightness;
            en_q     <= digit_en;
        end
    end

    // Load at the boundary cycle hands the older capture to the display and keeps the new one pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend[i] <= '0;
                disp[i] <= '0;
            end
        end else begin
            if (frame_end && pend_valid) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    disp[i] <= pend[i];
                end
            end
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    pend[i] <= digits_in[i*SEG_WIDTH +: SEG_WIDTH];
                end
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        anode_nxt = '0;
        seg_nxt   = '0;
        lit       = in_active && (phase < bright_eff) && en_eff[idx];
        if (lit) begin
            anode_nxt[idx] = 1'b1;
            seg_nxt        = disp[idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode_out   <= ANODE_OFF;
            seg_out     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            anode_out   <= anode_nxt ^ ANODE_OFF;
            seg_out     <= seg_nxt ^ SEG_OFF;
            frame_start <= slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a cycle-index reference model.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int SW    = 8;
    localparam int DC    = 16;
    localparam int BL    = 2;
    localparam int BW    = 2;
    localparam int FRAME = ND * DC;

    logic           clock = 1'b0;
    logic           reset;
    logic [ND*SW-1:0] digits_in = '0;
    logic           load = 1'b0;
    logic [ND-1:0]  digit_en = 4'hF;
    logic [BW-1:0]  brightness = 2'd3;
    logic [ND-1:0]  anode_out;
    logic [SW-1:0]  seg_out;
    logic           frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: k is the index of the next clock edge since reset release.
    int          k;
    logic [SW-1:0] m_pend [ND];
    logic [SW-1:0] m_disp [ND];
    bit          m_valid;
    int          m_bright;
    logic [ND-1:0] m_en;
    logic [ND-1:0] exp_anode;
    logic [SW-1:0] exp_seg;
    logic          exp_fs;

    seven_seg_scanner #(
        .NUM_DIGITS      (ND),
        .SEG_WIDTH       (SW),
        .DIGIT_CYCLES    (DC),
        .BLANK_CYCLES    (BL),
        .BRIGHT_W        (BW),
        .ANODE_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .digit_en   (digit_en),
        .brightness (brightness),
        .anode_out  (anode_out),
        .seg_out    (seg_out),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        k        = 0;
        m_valid  = 0;
        m_bright = 0;
        m_en     = '0;
        for (int i = 0; i < ND; i++) begin
            m_pend[i] = '0;
            m_disp[i] = '0;
        end
        exp_anode = 4'hF;
        exp_seg   = 8'hFF;
        exp_fs    = 1'b0;
    endtask

    // Called at each negedge, before inputs change, to advance by one clock edge.
    task automatic model_step();
        int c, d, ph;
        bit lit;
        c = k % DC;
        d = (k / DC) % ND;
        if (c == 0) begin
            m_bright = int'(brightness);
            m_en     = digit_en;
        end
        ph  = (c - BL) % (1 << BW);
        lit = (c >= BL) && (ph < m_bright) && (m_en[d] == 1'b1);
        exp_anode = lit ? ~(4'b0001 << d) : 4'hF;
        exp_seg   = lit ? ~m_disp[d] : 8'hFF;
        exp_fs    = ((k % FRAME) == 0);
        if ((k % FRAME) == FRAME - 1) begin
            if (m_valid) begin
                for (int i = 0; i < ND; i++) m_disp[i] = m_pend[i];
            end
            m_valid = 0;
        end
        if (load) begin
            for (int i = 0; i < ND; i++) m_pend[i] = digits_in[i*SW +: SW];
            m_valid = 1;
        end
        k++;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load       = 1'b0;
        digits_in  = '0;
        digit_en   = 4'hF;
        brightness = 2'd3;
        model_reset();
        repeat (3) @(negedge clock);
        n_tests++;
        if (anode_out !== 4'hF || seg_out !== 8'hFF || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold anode=%b seg=%h fs=%b want 1111/ff/0", anode_out, seg_out, frame_start);
        end
        reset = 1'b0;
        @(negedge clock); model_step();
        n_tests++;
        if (frame_start !== 1'b1 || anode_out !== 4'hF || seg_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL first_cycle anode=%b seg=%h fs=%b want 1111/ff/1", anode_out, seg_out, frame_start);
        end
    endtask

    task automatic test_free_run();
        int low_cnt [ND];
        int fs_cnt, last_fs;
        fs_cnt  = 0;
        last_fs = 0;
        for (int i = 0; i < ND; i++) low_cnt[i] = 0;
        for (int n = 0; n < 127; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL free_run e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            if (((k - 1) % DC) < BL) begin
                n_tests++;
                if (anode_out !== 4'hF) begin
                    n_fail++;
                    $display("FAIL blank_window e=%0d anode=%b want 1111", k-1, anode_out);
                end
            end
            for (int i = 0; i < ND; i++) if (anode_out[i] === 1'b0) low_cnt[i]++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                n_tests++;
                if ((k - 1) - last_fs != FRAME) begin
                    n_fail++;
                    $display("FAIL frame_period got %0d want %0d", (k - 1) - last_fs, FRAME);
                end
                last_fs = k - 1;
            end
        end
        n_tests++;
        if (fs_cnt != 1) begin
            n_fail++;
            $display("FAIL frame_start_count got %0d want 1", fs_cnt);
        end
        // Two frames, 11 lit cycles per digit each (phases 0..2 of 14 active cycles).
        for (int i = 0; i < ND; i++) begin
            n_tests++;
            if (low_cnt[i] != 22) begin
                n_fail++;
                $display("FAIL duty_digit%0d got %0d want 22", i, low_cnt[i]);
            end
        end
    endtask

    task automatic test_load_midframe();
        bit seen_fs, checked;
        seen_fs = 0;
        checked = 0;
        for (int n = 0; n < 160; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL load_mid e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            if (frame_start === 1'b1 && n > 20) seen_fs = 1;
            if (!seen_fs && n > 20 && anode_out === 4'b1110) begin
                n_tests++;
                if (seg_out !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL load_early e=%0d seg=%h want ff", k-1, seg_out);
                end
            end
            if (seen_fs && !checked && anode_out === 4'b1110) begin
                checked = 1;
                n_tests++;
                if (seg_out !== 8'hC0) begin
                    n_fail++;
                    $display("FAIL load_digit0 seg=%h want c0", seg_out);
                end
            end
            if (n == 20) begin
                digits_in = 32'h4F06_5B3F;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        n_tests++;
        if (!checked) begin
            n_fail++;
            $display("FAIL load_digit0_timeout seen_fs=%0d want 1", seen_fs);
        end
    endtask

    task automatic test_brightness();
        int slot_lit, slot_b, checks;
        bit slot_ok;
        slot_lit = 0;
        slot_b   = 0;
        slot_ok  = 0;
        checks   = 0;
        for (int n = 0; n < 140; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL brightness e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            if (((k - 1) % DC) == 0) begin
                slot_ok  = 1;
                slot_lit = 0;
                slot_b   = int'(brightness);
            end
            if (anode_out !== 4'hF) slot_lit++;
            if (slot_ok && ((k - 1) % DC) == DC - 1 && (slot_b == 2 || slot_b == 0)) begin
                checks++;
                n_tests++;
                if (slot_lit != ((slot_b == 2) ? 8 : 0)) begin
                    n_fail++;
                    $display("FAIL slot_lit b=%0d got %0d want %0d", slot_b, slot_lit, (slot_b == 2) ? 8 : 0);
                end
            end
            if (n == 5)  brightness = 2'd2;
            if (n == 69) brightness = 2'd0;
        end
        n_tests++;
        if (checks < 6) begin
            n_fail++;
            $display("FAIL slot_lit_checks got %0d want >=6", checks);
        end
        brightness = 2'd3;
    endtask

    task automatic test_digit_en();
        int last, intervals;
        last      = -1;
        intervals = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL digit_en e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            if (n > DC) begin
                n_tests++;
                if (anode_out[0] !== 1'b1 || anode_out[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL disabled_dark e=%0d anode=%b want bits0,2 high", k-1, anode_out);
                end
            end
            if (frame_start === 1'b1) begin
                if (last >= 0) begin
                    intervals++;
                    n_tests++;
                    if ((k - 1) - last != FRAME) begin
                        n_fail++;
                        $display("FAIL en_frame_period got %0d want %0d", (k - 1) - last, FRAME);
                    end
                end
                last = k - 1;
            end
            if (n == 0) digit_en = 4'b1010;
        end
        n_tests++;
        if (intervals < 1) begin
            n_fail++;
            $display("FAIL en_frame_count got %0d want >=1", intervals);
        end
        digit_en = 4'hF;
    endtask

    task automatic test_boundary_load();
        logic [31:0] p1, p2;
        bit p1_done, p2_done;
        int fs_after, chk1, chk2;
        p1 = 32'h065B_4F66;
        p2 = 32'h7D07_7F6F;
        p1_done  = 0;
        p2_done  = 0;
        fs_after = 0;
        chk1     = 0;
        chk2     = 0;
        for (int n = 0; n < 400 && fs_after < 3; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL boundary e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            if (p2_done && frame_start === 1'b1) fs_after++;
            if (anode_out === 4'b1110 && (fs_after == 1 || fs_after == 2)) begin
                n_tests++;
                if (fs_after == 1) chk1++; else chk2++;
                if (seg_out !== ((fs_after == 1) ? ~p1[7:0] : ~p2[7:0])) begin
                    n_fail++;
                    $display("FAIL boundary_frame%0d seg=%h want %h", fs_after, seg_out,
                             (fs_after == 1) ? ~p1[7:0] : ~p2[7:0]);
                end
            end
            load = 1'b0;
            if (!p1_done && (k % FRAME) == 30) begin
                digits_in = p1;
                load      = 1'b1;
                p1_done   = 1;
            end else if (p1_done && !p2_done && (k % FRAME) == FRAME - 1) begin
                digits_in = p2;
                load      = 1'b1;
                p2_done   = 1;
            end
        end
        load = 1'b0;
        n_tests++;
        if (chk1 == 0 || chk2 == 0) begin
            n_fail++;
            $display("FAIL boundary_timeout chk1=%0d chk2=%0d want both >0", chk1, chk2);
        end
    endtask

    task automatic test_reset_midframe();
        int lit_seen;
        lit_seen = 0;
        for (int n = 0; n < 200 && !((k % FRAME) == 24 && n > 20); n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL pre_reset e=%0d anode=%b exp %b seg=%h exp %h", k-1, anode_out, exp_anode, seg_out, exp_seg);
            end
            load = 1'b0;
            if ((k % FRAME) == 10) begin
                digits_in = 32'h3F3F_3F3F;
                load      = 1'b1;
            end
        end
        load = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (anode_out !== 4'hF || seg_out !== 8'hFF || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async anode=%b seg=%h fs=%b want 1111/ff/0", anode_out, seg_out, frame_start);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 140; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL post_reset e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            if (n == 0) begin
                n_tests++;
                if (frame_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL post_reset_fs fs=%b want 1", frame_start);
                end
            end
            if (anode_out !== 4'hF) begin
                lit_seen++;
                n_tests++;
                if (seg_out !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL pending_lost e=%0d seg=%h want ff", k-1, seg_out);
                end
            end
        end
        n_tests++;
        if (lit_seen == 0) begin
            n_fail++;
            $display("FAIL post_reset_lit got 0 lit cycles want >0");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6 * FRAME; n++) begin
            @(negedge clock); model_step();
            n_tests++;
            if (anode_out !== exp_anode || seg_out !== exp_seg || frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL random e=%0d anode=%b exp %b seg=%h exp %h fs=%b exp %b",
                         k-1, anode_out, exp_anode, seg_out, exp_seg, frame_start, exp_fs);
            end
            load = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                digits_in = $urandom;
                load      = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) brightness = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) digit_en   = 4'($urandom_range(0, 15));
        end
        load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_load_midframe();
        test_brightness();
        test_digit_en();
        test_boundary_load();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
